// File: rtl/arith_pkg.sv
// Shared arithmetic definitions: FSM state encoding for the bit-serial
// add/sub datapath and the default operand width.
package arith_pkg;

  localparam int DEFAULT_WIDTH = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } state_t;

endpackage : arith_pkg

// File: rtl/full_adder.sv
// One-bit full adder cell.
//   s   : sum bit
//   c   : carry out
//   a   : operand bit A
//   b   : operand bit B
//   cin : carry in
module full_adder (
  output logic s,
  output logic c,
  input  logic a,
  input  logic b,
  input  logic cin
);

  assign s = a ^ b ^ cin;
  assign c = (a & b) | (cin & (a ^ b));

endmodule : full_adder

// File: rtl/serial_add_sub.sv
// Bit-serial adder/subtractor. Operands load in parallel on start, one result
// bit is produced per clock LSB first through a single full_adder cell, and
// the parallel result is published with a one-cycle done pulse.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   start : request, accepted when busy = 0 (IDLE or DONE)
//   sub   : 0 = a + b, 1 = a - b (sampled with start)
//   a, b  : operands (sampled with start)
//   busy  : computation in progress
//   done  : one-cycle pulse when s/c/ovf update
//   s     : result, modulo 2^WIDTH
//   c     : carry out (subtract: 1 = no borrow)
//   ovf   : two's-complement overflow
//
// state | meaning
// IDLE  | waiting for start
// RUN   | one bit per cycle through the full adder, WIDTH cycles
// DONE  | result published, done high; start accepted back-to-back
module serial_add_sub
  import arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             c,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] ra_q, ra_d;
  logic [WIDTH-1:0] rb_q, rb_d;
  logic [WIDTH-1:0] rs_q, rs_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             c_q, c_d;
  logic             ovf_q, ovf_d;

  logic fa_s;
  logic fa_c;

  full_adder u_fa (
    .s   (fa_s),
    .c   (fa_c),
    .a   (ra_q[0]),
    .b   (rb_q[0]),
    .cin (carry_q)
  );

  always_comb begin
    state_d = state_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    rs_d    = rs_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    c_d     = c_q;
    ovf_d   = ovf_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          // Subtract as a + ~b + 1: invert b and seed the carry with 1.
          ra_d    = a;
          rb_d    = sub ? ~b : b;
          carry_d = sub;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        ra_d    = ra_q >> 1;
        rb_d    = rb_q >> 1;
        rs_d    = {fa_s, rs_q[WIDTH-1:1]};
        carry_d = fa_c;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          s_d     = rs_d;
          c_d     = fa_c;
          // On the MSB cycle carry_q is the carry into the sign bit.
          ovf_d   = carry_q ^ fa_c;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ra_q    <= '0;
      rb_q    <= '0;
      rs_q    <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      s_q     <= '0;
      c_q     <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      rs_q    <= rs_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      c_q     <= c_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign s    = s_q;
  assign c    = c_q;
  assign ovf  = ovf_q;

endmodule : serial_add_sub

// File: tb/tb_serial_add_sub.sv
module tb_serial_add_sub;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic       start8, sub8, busy8, done8, c8, ovf8;
  logic [7:0] a8, b8, s8;
  logic       start4, sub4, busy4, done4, c4, ovf4;
  logic [3:0] a4, b4, s4;

  int n_cmp = 0;
  int n_err = 0;

  serial_add_sub #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .sub(sub8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .s(s8), .c(c8), .ovf(ovf8)
  );

  serial_add_sub #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .sub(sub4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .s(s4), .c(c4), .ovf(ovf4)
  );

  // Reference: plain integer arithmetic, returns {c, ovf, s}.
  function automatic logic [9:0] model8(logic [7:0] a, logic [7:0] b, logic sub);
    int ua, ub, sa, sb, r;
    logic cc, ov;
    logic [7:0] ss;
    ua = a; ub = b;
    sa = (ua >= 128) ? ua - 256 : ua;
    sb = (ub >= 128) ? ub - 256 : ub;
    if (sub) begin
      r = sa - sb; cc = (ua >= ub); ss = 8'(ua - ub + 256);
    end else begin
      r = sa + sb; cc = (ua + ub) > 255; ss = 8'(ua + ub);
    end
    ov = (r > 127) || (r < -128);
    return {cc, ov, ss};
  endfunction

  function automatic logic [5:0] model4(logic [3:0] a, logic [3:0] b, logic sub);
    int ua, ub, sa, sb, r;
    logic cc, ov;
    logic [3:0] ss;
    ua = a; ub = b;
    sa = (ua >= 8) ? ua - 16 : ua;
    sb = (ub >= 8) ? ub - 16 : ub;
    if (sub) begin
      r = sa - sb; cc = (ua >= ub); ss = 4'(ua - ub + 16);
    end else begin
      r = sa + sb; cc = (ua + ub) > 15; ss = 4'(ua + ub);
    end
    ov = (r > 7) || (r < -8);
    return {cc, ov, ss};
  endfunction

  // Called at a negedge with the DUT in IDLE or DONE. Returns at the negedge
  // where done is first seen (or after a cycle budget expires).
  task automatic do_op8(input logic [7:0] ia, input logic [7:0] ib, input logic isub,
                        output logic [9:0] res, output int lat,
                        output bit busy_ok, output bit hold_ok);
    logic [7:0] prev_s;
    prev_s = s8;
    a8 = ia; b8 = ib; sub8 = isub; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    lat = 0; busy_ok = 1'b1; hold_ok = 1'b1;
    while (!done8 && lat < 40) begin
      if (busy8 !== 1'b1) busy_ok = 1'b0;
      if (s8 !== prev_s) hold_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    res = {c8, ovf8, s8};
  endtask

  task automatic do_op4(input logic [3:0] ia, input logic [3:0] ib, input logic isub,
                        output logic [5:0] res, output int lat);
    a4 = ia; b4 = ib; sub4 = isub; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    lat = 0;
    while (!done4 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    res = {c4, ovf4, s4};
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy8, done8, s8, c8, ovf8} !== 11'd0) begin
      n_err++;
      $display("FAIL reset8: got busy=%b done=%b s=%h c=%b ovf=%b, expected all 0",
               busy8, done8, s8, c8, ovf8);
    end
    n_cmp++;
    if ({busy4, done4, s4, c4, ovf4} !== 7'd0) begin
      n_err++;
      $display("FAIL reset4: got busy=%b done=%b s=%h c=%b ovf=%b, expected all 0",
               busy4, done4, s4, c4, ovf4);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [7:0] ta [4] = '{8'h5A, 8'hFF, 8'h00, 8'h80};
    logic [7:0] tb [4] = '{8'h3C, 8'h01, 8'h01, 8'h01};
    logic       tsub [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [9:0] texp [4] = '{{1'b0, 1'b1, 8'h96}, {1'b1, 1'b0, 8'h00},
                             {1'b0, 1'b0, 8'hFF}, {1'b1, 1'b1, 8'h7F}};
    logic [9:0] res;
    int lat;
    bit busy_ok, hold_ok;
    for (int i = 0; i < 4; i++) begin
      do_op8(ta[i], tb[i], tsub[i], res, lat, busy_ok, hold_ok);
      n_cmp++;
      if (res !== texp[i]) begin
        n_err++;
        $display("FAIL directed[%0d] result: got c=%b ovf=%b s=%h, expected c=%b ovf=%b s=%h",
                 i, res[9], res[8], res[7:0], texp[i][9], texp[i][8], texp[i][7:0]);
      end
      n_cmp++;
      if (lat != 8) begin
        n_err++;
        $display("FAIL directed[%0d] latency: got %0d, expected 8", i, lat);
      end
      n_cmp++;
      if (!busy_ok || !hold_ok || busy8 !== 1'b0) begin
        n_err++;
        $display("FAIL directed[%0d] busy/hold: got busy_ok=%b hold_ok=%b busy_at_done=%b, expected 1 1 0",
                 i, busy_ok, hold_ok, busy8);
      end
      @(negedge clk);
      n_cmp++;
      if (done8 !== 1'b0 || busy8 !== 1'b0) begin
        n_err++;
        $display("FAIL directed[%0d] done_pulse: got done=%b busy=%b after pulse, expected 0 0",
                 i, done8, busy8);
      end
    end
  endtask

  task automatic test_ignored_start();
    int n;
    bit quiet;
    a8 = 8'h33; b8 = 8'h44; sub8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    n = 0;
    while (!done8 && n < 40) begin
      @(negedge clk);
      n++;
      if (n == 2) begin
        a8 = 8'h11; b8 = 8'h22; sub8 = 1'b1; start8 = 1'b1;
      end else begin
        start8 = 1'b0;
      end
    end
    n_cmp++;
    if ({c8, ovf8, s8} !== {1'b0, 1'b0, 8'h77} || n != 8) begin
      n_err++;
      $display("FAIL ignored_start: got c=%b ovf=%b s=%h lat=%0d, expected c=0 ovf=0 s=77 lat=8",
               c8, ovf8, s8, n);
    end
    quiet = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (busy8 !== 1'b0 || done8 !== 1'b0) quiet = 1'b0;
    end
    n_cmp++;
    if (!quiet) begin
      n_err++;
      $display("FAIL ignored_start_quiet: got activity after completion, expected busy=0 done=0");
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0] res;
    int lat;
    bit busy_ok, hold_ok;
    do_op8(8'h5A, 8'h3C, 1'b0, res, lat, busy_ok, hold_ok);
    n_cmp++;
    if (res !== {1'b0, 1'b1, 8'h96} || lat != 8) begin
      n_err++;
      $display("FAIL b2b_first: got c=%b ovf=%b s=%h lat=%0d, expected c=0 ovf=1 s=96 lat=8",
               res[9], res[8], res[7:0], lat);
    end
    do_op8(8'h10, 8'h01, 1'b1, res, lat, busy_ok, hold_ok);
    n_cmp++;
    if (res !== {1'b1, 1'b0, 8'h0F} || lat != 8) begin
      n_err++;
      $display("FAIL b2b_second: got c=%b ovf=%b s=%h lat=%0d, expected c=1 ovf=0 s=0f lat=8",
               res[9], res[8], res[7:0], lat);
    end
    n_cmp++;
    if (!busy_ok || !hold_ok) begin
      n_err++;
      $display("FAIL b2b_busy_hold: got busy_ok=%b hold_ok=%b, expected 1 1", busy_ok, hold_ok);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run();
    logic [9:0] res;
    int lat;
    bit busy_ok, hold_ok, quiet;
    a8 = 8'h5A; b8 = 8'h3C; sub8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy8, done8, s8, c8, ovf8} !== 11'd0) begin
      n_err++;
      $display("FAIL reset_mid_run: got busy=%b done=%b s=%h c=%b ovf=%b, expected all 0",
               busy8, done8, s8, c8, ovf8);
    end
    @(negedge clk);
    rst_n = 1'b1;
    quiet = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (busy8 !== 1'b0 || done8 !== 1'b0 || s8 !== 8'h00) quiet = 1'b0;
    end
    n_cmp++;
    if (!quiet) begin
      n_err++;
      $display("FAIL reset_no_done: got activity or nonzero s after abort, expected idle with s=00");
    end
    do_op8(8'h7F, 8'h01, 1'b0, res, lat, busy_ok, hold_ok);
    n_cmp++;
    if (res !== model8(8'h7F, 8'h01, 1'b0) || lat != 8) begin
      n_err++;
      $display("FAIL reset_recover: got c=%b ovf=%b s=%h lat=%0d, expected c=0 ovf=1 s=80 lat=8",
               res[9], res[8], res[7:0], lat);
    end
    @(negedge clk);
  endtask

  task automatic test_random8();
    logic [7:0] ra, rb;
    logic rsub;
    logic [9:0] res, exp;
    int lat;
    bit busy_ok, hold_ok;
    for (int i = 0; i < 150; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rsub = 1'($urandom);
      exp = model8(ra, rb, rsub);
      do_op8(ra, rb, rsub, res, lat, busy_ok, hold_ok);
      n_cmp++;
      if (res !== exp || lat != 8 || !busy_ok || !hold_ok) begin
        n_err++;
        $display("FAIL random8 a=%h b=%h sub=%b: got c=%b ovf=%b s=%h lat=%0d busy_ok=%b hold_ok=%b, expected c=%b ovf=%b s=%h lat=8 1 1",
                 ra, rb, rsub, res[9], res[8], res[7:0], lat, busy_ok, hold_ok,
                 exp[9], exp[8], exp[7:0]);
      end
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic test_exhaustive4();
    logic [5:0] res, exp;
    int lat;
    for (int sb = 0; sb < 2; sb++) begin
      for (int ia = 0; ia < 16; ia++) begin
        for (int ib = 0; ib < 16; ib++) begin
          exp = model4(4'(ia), 4'(ib), 1'(sb));
          do_op4(4'(ia), 4'(ib), 1'(sb), res, lat);
          n_cmp++;
          if (res !== exp || lat != 4) begin
            n_err++;
            $display("FAIL exhaustive4 a=%h b=%h sub=%0d: got c=%b ovf=%b s=%h lat=%0d, expected c=%b ovf=%b s=%h lat=4",
                     ia, ib, sb, res[5], res[4], res[3:0], lat, exp[5], exp[4], exp[3:0]);
          end
        end
      end
    end
    @(negedge clk);
  endtask

  initial begin
    start8 = 1'b0; sub8 = 1'b0; a8 = '0; b8 = '0;
    start4 = 1'b0; sub4 = 1'b0; a4 = '0; b4 = '0;
    rst_n = 1'b0;
    test_reset();
    test_directed();
    test_ignored_start();
    test_back_to_back();
    test_reset_mid_run();
    test_random8();
    test_exhaustive4();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_serial_add_sub
